// File: rtl/ddr_line_ctrl.sv
// Cache-line adapter: one line request becomes BEATS MIG app_* commands plus write/read data beats.
// Optional DDR_LINE_HIT_EN keeps a one-line tag so repeat reads of the held line skip the MIG.
module ddr_line_ctrl #(
   parameter int DATA_W     = 128,
   parameter int BEATS      = 2,
   parameter int ADDR_W     = 27,
   parameter int CPU_ADDR_W = 30,
   parameter int ADDR_STEP  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        calib_done,
   input  logic                        req_valid,
   input  logic                        req_write,
   input  logic [CPU_ADDR_W-1:0]       req_addr,
   input  logic [DATA_W*BEATS-1:0]     req_wdata,
   output logic                        req_ready,
   output logic                        rsp_valid,
   output logic [DATA_W*BEATS-1:0]     rsp_rdata,
   output logic                        busy,
   output logic [ADDR_W-1:0]           app_addr,
   output logic [2:0]                  app_cmd,
   output logic                        app_en,
   input  logic                        app_rdy,
   output logic [DATA_W-1:0]           app_wdf_data,
   output logic [DATA_W/8-1:0]         app_wdf_mask,
   output logic                        app_wdf_wren,
   output logic                        app_wdf_end,
   input  logic                        app_wdf_rdy,
   input  logic [DATA_W-1:0]           app_rd_data,
   input  logic                        app_rd_data_valid,
   input  logic                        app_rd_data_end
);

   localparam int LINE_W = DATA_W * BEATS;
   localparam int WPL    = LINE_W / 32;
   localparam int WPL_LG = (WPL > 1) ? $clog2(WPL) : 0;
   localparam int CNT_W  = $clog2(BEATS + 1);
   localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);

   typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

   state_t             state_q;
   logic               alive_q;
   logic [ADDR_W-1:0]  base_q;
   logic [LINE_W-1:0]  wline_q;
   logic [LINE_W-1:0]  rdLine_q, rdLine_d;
   logic [LINE_W-1:0]  rspRdata_q;
   logic [CNT_W-1:0]   cmdCnt_q, cmdCnt_d;
   logic [CNT_W-1:0]   wdfCnt_q, wdfCnt_d;
   logic [CNT_W-1:0]   rdCnt_q, rdCnt_d;
   logic [ADDR_W-1:0]  reqBase;
   logic [BIDX_W-1:0]  wdfIdx;
   logic               cmdFire, wdfFire, rdFire, wrDone, rdDone, lineHit;
   logic               unusedRdDataEnd;

   assign unusedRdDataEnd = app_rd_data_end;

   // Line base in MIG address units; overflow wraps within ADDR_W.
   assign reqBase = ADDR_W'(req_addr >> WPL_LG) * ADDR_W'(BEATS * ADDR_STEP);
   assign wdfIdx  = (BEATS > 1) ? wdfCnt_q[BIDX_W-1:0] : '0;

   assign app_en       = (state_q == WR || state_q == RD) && (cmdCnt_q < BEATS_C);
   assign app_cmd      = (state_q == WR) ? 3'b000 : 3'b001;
   assign app_addr     = base_q + ADDR_W'(cmdCnt_q) * ADDR_W'(ADDR_STEP);
   assign app_wdf_wren = (state_q == WR) && (wdfCnt_q < BEATS_C);
   assign app_wdf_end  = app_wdf_wren;
   assign app_wdf_data = wline_q[wdfIdx*DATA_W +: DATA_W];
   assign app_wdf_mask = '0;

   assign req_ready = (state_q == IDLE) && calib_done && alive_q;
   assign busy      = (state_q != IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rspRdata_q;

   assign cmdFire = app_en & app_rdy;
   assign wdfFire = app_wdf_wren & app_wdf_rdy;
   assign rdFire  = (state_q == RD) && app_rd_data_valid && (rdCnt_q < BEATS_C);

`ifdef DDR_LINE_HIT_EN
   logic [ADDR_W-1:0] tag_q;
   logic              tagValid_q;
   assign lineHit = tagValid_q && (tag_q == reqBase);
`else
   assign lineHit = 1'b0;
`endif

   // Next counter values let the FSM leave WR/RD in the same cycle the last beat is taken.
   always_comb begin
      cmdCnt_d = cmdCnt_q + CNT_W'(cmdFire);
      wdfCnt_d = wdfCnt_q + CNT_W'(wdfFire);
      rdCnt_d  = rdCnt_q + CNT_W'(rdFire);
      rdLine_d = rdLine_q;
      for (int b = 0; b < BEATS; b++) begin
         if (rdFire && rdCnt_q == CNT_W'(b)) begin
            rdLine_d[b*DATA_W +: DATA_W] = app_rd_data;
         end
      end
      wrDone = (cmdCnt_d == BEATS_C) && (wdfCnt_d == BEATS_C);
      rdDone = (rdCnt_d == BEATS_C);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         alive_q    <= 1'b0;
         base_q     <= '0;
         wline_q    <= '0;
         rdLine_q   <= '0;
         rspRdata_q <= '0;
         cmdCnt_q   <= '0;
         wdfCnt_q   <= '0;
         rdCnt_q    <= '0;
`ifdef DDR_LINE_HIT_EN
         tag_q      <= '0;
         tagValid_q <= 1'b0;
`endif
      end else begin
         alive_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (req_valid && req_ready) begin
                  base_q   <= reqBase;
                  wline_q  <= req_wdata;
                  cmdCnt_q <= '0;
                  wdfCnt_q <= '0;
                  rdCnt_q  <= '0;
                  if (req_write) begin
                     state_q <= WR;
                     if (lineHit) rspRdata_q <= req_wdata;
                  end else if (lineHit) begin
                     state_q <= RESP;
                  end else begin
                     state_q <= RD;
                  end
               end
            end
            WR: begin
               cmdCnt_q <= cmdCnt_d;
               wdfCnt_q <= wdfCnt_d;
               if (wrDone) state_q <= RESP;
            end
            RD: begin
               cmdCnt_q <= cmdCnt_d;
               rdCnt_q  <= rdCnt_d;
               rdLine_q <= rdLine_d;
               if (rdDone) begin
                  state_q    <= RESP;
                  rspRdata_q <= rdLine_d;
`ifdef DDR_LINE_HIT_EN
                  tag_q      <= base_q;
                  tagValid_q <= 1'b1;
`endif
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_line_ctrl.sv
// Scoreboard bench for ddr_line_ctrl: expected MIG commands, write beats and responses are queued
// when a request is driven and checked as the DUT produces them.
module tb_ddr_line_ctrl;

   localparam int DATA_W = 128;
   localparam int BEATS  = 2;
   localparam int ADDR_W = 27;
   localparam int LINE_W = DATA_W * BEATS;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [2:0]        cmd;
   } cmd_t;

   typedef struct packed {
      logic              isRead;
      logic [LINE_W-1:0] data;
   } rsp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              calib_done;
   logic              req_valid;
   logic              req_write;
   logic [29:0]       req_addr;
   logic [LINE_W-1:0] req_wdata;
   logic              req_ready;
   logic              rsp_valid;
   logic [LINE_W-1:0] rsp_rdata;
   logic              busy;
   logic [ADDR_W-1:0] app_addr;
   logic [2:0]        app_cmd;
   logic              app_en;
   logic              app_rdy;
   logic [DATA_W-1:0] app_wdf_data;
   logic [15:0]       app_wdf_mask;
   logic              app_wdf_wren;
   logic              app_wdf_end;
   logic              app_wdf_rdy;
   logic [DATA_W-1:0] app_rd_data;
   logic              app_rd_data_valid;
   logic              app_rd_data_end;

   ddr_line_ctrl dut (
      .clk(clk), .rst(rst), .calib_done(calib_done),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
      .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
      .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
      .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
      .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
      .app_rd_data_end(app_rd_data_end)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acceptCyc = 0;
   int   rspCyc = 0;
   int   rspCount = 0;
   int   rspBefore = 0;
   cmd_t expCmd[$];
   logic [DATA_W-1:0] expWdf[$];
   rsp_t expRsp[$];

   cmd_t              popCmd;
   rsp_t              popRsp;
   logic [DATA_W-1:0] popWdf;
   logic              stallCmd = 1'b0, stallWdf = 1'b0;
   logic [ADDR_W-1:0] heldAddr;
   logic [2:0]        heldCmd;
   logic [DATA_W-1:0] heldWdf;

   localparam logic [LINE_W-1:0] LINE_D = {{4{32'h2222_0B01}}, {4{32'h1111_0A01}}};
   localparam logic [LINE_W-1:0] LINE_S = {{4{32'h4444_0B02}}, {4{32'h3333_0A02}}};
   localparam logic [LINE_W-1:0] LINE_H = {{4{32'h6666_0B03}}, {4{32'h5555_0A03}}};
   localparam logic [DATA_W-1:0] BEAT_A = {4{32'hAAAA_AAAA}};
   localparam logic [DATA_W-1:0] BEAT_B = {4{32'hBBBB_BBBB}};
   localparam logic [DATA_W-1:0] BEAT_C = {4{32'hCCCC_0001}};
   localparam logic [DATA_W-1:0] BEAT_D = {4{32'hDDDD_0002}};
   localparam logic [DATA_W-1:0] BEAT_E = {4{32'hEEEE_0003}};
   localparam logic [DATA_W-1:0] BEAT_F = {4{32'hF0F0_0004}};
   localparam logic [DATA_W-1:0] BEAT_G = {4{32'h0F0F_0005}};

   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point for every check in the bench.
   task automatic checkOutput(input string tag, input logic [LINE_W-1:0] actual,
                              input logic [LINE_W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic pushWrite(input logic [ADDR_W-1:0] base, input logic [LINE_W-1:0] line);
      for (int i = 0; i < BEATS; i++) begin
         expCmd.push_back('{addr: base + ADDR_W'(16 * i), cmd: 3'b000});
         expWdf.push_back(line[i*DATA_W +: DATA_W]);
      end
      expRsp.push_back('{isRead: 1'b0, data: '0});
   endtask

   task automatic pushRead(input logic [ADDR_W-1:0] base, input logic [LINE_W-1:0] line,
                           input logic viaMig);
      if (viaMig) begin
         for (int i = 0; i < BEATS; i++) expCmd.push_back('{addr: base + ADDR_W'(16 * i), cmd: 3'b001});
      end
      expRsp.push_back('{isRead: 1'b1, data: line});
   endtask

   // Presents a request, waits for acceptance and returns one cycle after it (cycle N+1, #1).
   task automatic applyStimulus(input logic wr, input logic [29:0] addr, input logic [LINE_W-1:0] wdata);
      logic got;
      rspBefore = rspCount;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (req_ready) got = 1'b1;
      end
      checkOutput("reqAccepted", got, 1);
      acceptCyc = cyc;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_wdata = '0;
      checkOutput("readyDropped", req_ready, 0);
      checkOutput("busyAfterAccept", busy, 1);
   endtask

   task automatic waitRsp(input string tag, input int expLat);
      for (int i = 0; i < 60 && rspCount == rspBefore; i++) begin
         @(negedge clk);
         #1;
      end
      checkOutput({tag, "RspCount"}, rspCount - rspBefore, 1);
      checkOutput({tag, "Latency"}, rspCyc - acceptCyc, expLat);
   endtask

   task automatic readBeat(input logic [DATA_W-1:0] beat);
      app_rd_data_valid = 1'b1;
      app_rd_data       = beat;
      @(posedge clk);
      #1;
      app_rd_data_valid = 1'b0;
      app_rd_data       = '0;
   endtask

   // Monitor: pops the scoreboard on every MIG handshake and response, and checks stall stability.
   always @(negedge clk) begin
      if (rst) begin
         stallCmd = 1'b0;
         stallWdf = 1'b0;
      end else begin
         if (stallCmd) begin
            checkOutput("stallEn", app_en, 1);
            checkOutput("stallAddr", app_addr, heldAddr);
            checkOutput("stallCmd", app_cmd, heldCmd);
         end
         if (stallWdf) begin
            checkOutput("stallWren", app_wdf_wren, 1);
            checkOutput("stallWdfData", app_wdf_data, heldWdf);
         end
         stallCmd = app_en && !app_rdy;
         stallWdf = app_wdf_wren && !app_wdf_rdy;
         heldAddr = app_addr;
         heldCmd  = app_cmd;
         heldWdf  = app_wdf_data;
         if (app_en && app_rdy) begin
            if (expCmd.size() == 0) checkOutput("cmdPending", expCmd.size(), 1);
            else begin
               popCmd = expCmd.pop_front();
               checkOutput("cmdAddr", app_addr, popCmd.addr);
               checkOutput("cmdCode", app_cmd, popCmd.cmd);
            end
         end
         if (app_wdf_wren && app_wdf_rdy) begin
            if (expWdf.size() == 0) checkOutput("wdfPending", expWdf.size(), 1);
            else begin
               popWdf = expWdf.pop_front();
               checkOutput("wdfData", app_wdf_data, popWdf);
               checkOutput("wdfEnd", app_wdf_end, 1);
               checkOutput("wdfMask", app_wdf_mask, 0);
            end
         end
         if (rsp_valid) begin
            rspCount++;
            rspCyc = cyc;
            checkOutput("rspReadyLow", req_ready, 0);
            if (expRsp.size() == 0) checkOutput("rspPending", expRsp.size(), 1);
            else begin
               popRsp = expRsp.pop_front();
               if (popRsp.isRead) checkOutput("rspData", rsp_rdata, popRsp.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; calib_done = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      app_rd_data = '0; app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;

      // Reset values.
      repeat (3) @(negedge clk);
      checkOutput("rstAppEn", app_en, 0);
      checkOutput("rstAppCmd", app_cmd, 3'b001);
      checkOutput("rstAppAddr", app_addr, 0);
      checkOutput("rstWren", app_wdf_wren, 0);
      checkOutput("rstWdfEnd", app_wdf_end, 0);
      checkOutput("rstWdfData", app_wdf_data, 0);
      checkOutput("rstReady", req_ready, 0);
      checkOutput("rstRspValid", rsp_valid, 0);
      checkOutput("rstRspData", rsp_rdata, 0);
      checkOutput("rstBusy", busy, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      calib_done = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("readyAfterCalib", req_ready, 1);

      // Full-speed write: word 0x20 -> base 0x80, beats at 0x80/0x90, response at N+3.
      pushWrite(27'h80, LINE_D);
      applyStimulus(1'b1, 30'h20, LINE_D);
      waitRsp("wrFast", 3);

      // Write with data channel stalled three cycles while commands run ahead.
      app_wdf_rdy = 1'b0;
      pushWrite(27'h48C0, LINE_S);
      applyStimulus(1'b1, 30'h1234, LINE_S);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      app_wdf_rdy = 1'b1;
      waitRsp("wrStall", 6);

      // Stray read data in IDLE is ignored; read 0x8 with first beat alongside 2nd command,
      // calib_done dropping mid-transaction.
      app_rd_data_valid = 1'b1; app_rd_data = BEAT_E;
      @(posedge clk); #1;
      app_rd_data_valid = 1'b0; app_rd_data = '0;
      pushRead(27'h20, {BEAT_B, BEAT_A}, 1'b1);
      applyStimulus(1'b0, 30'h8, '0);
      calib_done = 1'b0;
      @(posedge clk); #1;
      readBeat(BEAT_A);
      readBeat(BEAT_B);
      calib_done = 1'b1;
      waitRsp("rdBasic", 4);

      // app_rdy toggling during a read: exactly two commands, address held while stalled.
      app_rdy = 1'b0;
      pushRead(27'h400, {BEAT_D, BEAT_C}, 1'b1);
      applyStimulus(1'b0, 30'h100, '0);
      for (int i = 1; i < 6; i++) begin
         @(posedge clk); #1;
         app_rdy = i[0];
         app_rd_data_valid = (i >= 4);
         app_rd_data = (i == 4) ? BEAT_C : ((i == 5) ? BEAT_D : '0);
      end
      @(posedge clk); #1;
      app_rd_data_valid = 1'b0; app_rd_data = '0; app_rdy = 1'b1;
      waitRsp("rdToggle", 7);
      checkOutput("toggleCmdsDrained", expCmd.size(), 0);

      // Reset in the middle of a read after one beat.
      expCmd.push_back('{addr: 27'h40, cmd: 3'b001});
      expCmd.push_back('{addr: 27'h50, cmd: 3'b001});
      applyStimulus(1'b0, 30'h10, '0);
      @(posedge clk); #1;
      readBeat(BEAT_E);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("abortAppEn", app_en, 0);
      checkOutput("abortAppCmd", app_cmd, 3'b001);
      checkOutput("abortAppAddr", app_addr, 0);
      checkOutput("abortBusy", busy, 0);
      checkOutput("abortReady", req_ready, 0);
      checkOutput("abortRspData", rsp_rdata, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("abortRspCount", rspCount - rspBefore, 0);
      pushRead(27'h40, {BEAT_G, BEAT_F}, 1'b1);
      applyStimulus(1'b0, 30'h10, '0);
      @(posedge clk); #1;
      readBeat(BEAT_F);
      readBeat(BEAT_G);
      waitRsp("rdAfterAbort", 4);

`ifdef DDR_LINE_HIT_EN
      // Repeat read hits the held line without MIG traffic; a write to it is written through.
      pushRead(27'h40, {BEAT_G, BEAT_F}, 1'b0);
      applyStimulus(1'b0, 30'h10, '0);
      waitRsp("rdHit", 1);
      pushWrite(27'h40, LINE_H);
      applyStimulus(1'b1, 30'h13, LINE_H);
      waitRsp("wrHit", 3);
      checkOutput("writeThrough", rsp_rdata, LINE_H);
      pushRead(27'h40, LINE_H, 1'b0);
      applyStimulus(1'b0, 30'h10, '0);
      waitRsp("rdHitAfterWr", 1);
`endif

      repeat (3) @(negedge clk);
      checkOutput("cmdQueueEmpty", expCmd.size(), 0);
      checkOutput("wdfQueueEmpty", expWdf.size(), 0);
      checkOutput("rspQueueEmpty", expRsp.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
